garage_door_actuator: RTL and testbench



---
 rtl/garage_door_actuator_if.sv | 25 ++
 rtl/garage_door_actuator.sv | 137 +++++++++++++
 tb/tb_garage_door_actuator.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/garage_door_actuator_if.sv
// Door motor interface: the controller drives the motor command side,
// the actuator drives back the limit sensors and motion status.
interface garage_door_actuator_if #(
  parameter int unsigned POS_W = 8
);
  logic [1:0]       control;
  logic             obstruction;
  logic             fault_clr;
  logic             sensor1;
  logic             sensor2;
  logic [POS_W-1:0] position;
  logic             moving;
  logic             dir;
  logic             fault;

  modport master (
    output control, obstruction, fault_clr,
    input  sensor1, sensor2, position, moving, dir, fault
  );

  modport slave (
    input  control, obstruction, fault_clr,
    output sensor1, sensor2, position, moving, dir, fault
  );
endinterface

// File: rtl/garage_door_actuator.sv
// Garage door motor/mechanism model: position counter with step prescaler,
// reversal dead-time and obstruction fault while closing.
module garage_door_actuator #(
  parameter int unsigned TRAVEL   = 100,
  parameter int unsigned STEP_DIV = 4,
  parameter int unsigned DEADTIME = 8,
  parameter int unsigned POS_W    = 8
) (
  input logic                   clk,
  input logic                   rst,
  garage_door_actuator_if.slave bus
);

  localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned DW = $clog2(DEADTIME + 1);

  localparam logic [POS_W-1:0] TRAVEL_P   = POS_W'(TRAVEL);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0]    DEAD_LOAD  = DW'(DEADTIME);

  typedef enum logic [2:0] {
    ST_STOPPED,
    ST_MOVING_UP,
    ST_MOVING_DOWN,
    ST_DEAD,
    ST_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DW-1:0]    dead_q, dead_d;
  logic             dir_q, dir_d;

  logic up_req;
  logic dn_req;

  assign up_req = (bus.control == 2'b10);
  assign dn_req = (bus.control == 2'b11);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    dead_d  = dead_q;
    dir_d   = dir_q;
    case (state_q)
      ST_STOPPED: begin
        if (up_req && (pos_q < TRAVEL_P)) begin
          state_d = ST_MOVING_UP;
          dir_d   = 1'b1;
          presc_d = '0;
        end else if (dn_req && (pos_q != '0)) begin
          state_d = ST_MOVING_DOWN;
          dir_d   = 1'b0;
          presc_d = '0;
        end
      end
      ST_MOVING_UP: begin
        // Command drop outranks a limit step landing on the same edge.
        if (!up_req) begin
          state_d = ST_DEAD;
          dead_d  = DEAD_LOAD;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (pos_q >= TRAVEL_P - 1'b1) begin
            pos_d   = TRAVEL_P;
            state_d = ST_DEAD;
            dead_d  = DEAD_LOAD;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_MOVING_DOWN: begin
        if (bus.obstruction) begin
          state_d = ST_FAULT;
        end else if (!dn_req) begin
          state_d = ST_DEAD;
          dead_d  = DEAD_LOAD;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (pos_q <= POS_W'(1)) begin
            pos_d   = '0;
            state_d = ST_DEAD;
            dead_d  = DEAD_LOAD;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_DEAD: begin
        if (dead_q <= DW'(1)) begin
          state_d = ST_STOPPED;
          dead_d  = '0;
        end else begin
          dead_d = dead_q - 1'b1;
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr && !bus.obstruction) begin
          state_d = ST_DEAD;
          dead_d  = DEAD_LOAD;
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOPPED;
      pos_q   <= '0;
      presc_q <= '0;
      dead_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      dead_q  <= dead_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.position = pos_q;
  assign bus.sensor1  = (pos_q == TRAVEL_P);
  assign bus.sensor2  = (pos_q == '0);
  assign bus.moving   = (state_q == ST_MOVING_UP) || (state_q == ST_MOVING_DOWN);
  assign bus.dir      = dir_q;
  assign bus.fault    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_garage_door_actuator.sv
// Directed plus random stimulus against a cycle-level behavioural door model.
module tb_garage_door_actuator;

  localparam int TRAVEL   = 10;
  localparam int STEP_DIV = 2;
  localparam int DEADTIME = 3;
  localparam int POS_W    = 8;

  logic clk;
  logic rst;

  int n_asserts = 0;
  int n_fail    = 0;

  // Behavioural model: motion is -1/0/+1, hold counts remaining dead cycles.
  int m_pos, m_motion, m_hold, m_ticks;
  bit m_fault, m_dir;

  garage_door_actuator_if #(.POS_W(POS_W)) bus ();

  garage_door_actuator #(
    .TRAVEL  (TRAVEL),
    .STEP_DIV(STEP_DIV),
    .DEADTIME(DEADTIME),
    .POS_W   (POS_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pos = 0; m_motion = 0; m_hold = 0; m_ticks = 0; m_fault = 0; m_dir = 0;
  endtask

  task automatic model_step(input logic [1:0] c, input logic o, input logic f);
    int want;
    want = (c == 2'b10) ? 1 : ((c == 2'b11) ? -1 : 0);
    if (m_fault) begin
      if (f && !o) begin m_fault = 0; m_hold = DEADTIME; end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_motion == 0) begin
      if (want == 1 && m_pos < TRAVEL) begin
        m_motion = 1; m_dir = 1; m_ticks = 0;
      end else if (want == -1 && m_pos > 0) begin
        m_motion = -1; m_dir = 0; m_ticks = 0;
      end
    end else if (m_motion == -1 && o) begin
      m_motion = 0; m_fault = 1;
    end else if (want != m_motion) begin
      m_motion = 0; m_hold = DEADTIME;
    end else begin
      m_ticks++;
      if (m_ticks % STEP_DIV == 0) begin
        m_pos += m_motion;
        if (m_pos == 0 || m_pos == TRAVEL) begin
          m_motion = 0; m_hold = DEADTIME;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("position", 32'(bus.position), 32'(m_pos));
    chk("sensor1",  32'(bus.sensor1),  32'(m_pos == TRAVEL));
    chk("sensor2",  32'(bus.sensor2),  32'(m_pos == 0));
    chk("moving",   32'(bus.moving),   32'(m_motion != 0));
    chk("dir",      32'(bus.dir),      32'(m_dir));
    chk("fault",    32'(bus.fault),    32'(m_fault));
  endtask

  task automatic tick();
    logic [1:0] c;
    logic o, f;
    @(posedge clk);
    c = bus.control; o = bus.obstruction; f = bus.fault_clr;
    model_step(c, o, f);
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.control = 2'b00; bus.obstruction = 1'b0; bus.fault_clr = 1'b0;
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #2;
    check_model();
    chk("rst_sensor2", 32'(bus.sensor2), 32'd1);
    chk("rst_moving",  32'(bus.moving),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Open fully, then close fully
    bus.control = 2'b10;
    tick();
    chk("open_moving", 32'(bus.moving), 32'd1);
    chk("open_dir",    32'(bus.dir),    32'd1);
    ticks(19);
    chk("open_pos9",   32'(bus.position), 32'd9);
    tick();
    chk("open_pos10",  32'(bus.position), 32'd10);
    chk("open_s1",     32'(bus.sensor1),  32'd1);
    chk("open_stop",   32'(bus.moving),   32'd0);
    bus.control = 2'b11;
    ticks(3);
    chk("close_dead",  32'(bus.moving), 32'd0);
    tick();
    chk("close_start", 32'(bus.moving), 32'd1);
    chk("close_dir",   32'(bus.dir),    32'd0);
    ticks(20);
    chk("close_pos0",  32'(bus.position), 32'd0);
    chk("close_s2",    32'(bus.sensor2),  32'd1);

    // Reversal mid-travel
    bus.control = 2'b10;
    ticks(4);
    chk("rev_up", 32'(bus.moving), 32'd1);
    ticks(8);
    chk("rev_pos4", 32'(bus.position), 32'd4);
    bus.control = 2'b11;
    tick();
    chk("rev_drop", 32'(bus.moving), 32'd0);
    ticks(3);
    chk("rev_hold", 32'(bus.position), 32'd4);
    tick();
    chk("rev_down", 32'(bus.moving), 32'd1);
    chk("rev_dir",  32'(bus.dir),    32'd0);
    ticks(8);
    chk("rev_pos0", 32'(bus.position), 32'd0);

    // Obstruction ignored going up, faults going down
    bus.control = 2'b10; bus.obstruction = 1'b1;
    ticks(16);
    chk("obs_up_pos6",  32'(bus.position), 32'd6);
    chk("obs_up_fault", 32'(bus.fault),    32'd0);
    bus.obstruction = 1'b0; bus.control = 2'b11;
    ticks(5);
    chk("obs_dn_moving", 32'(bus.moving), 32'd1);
    bus.obstruction = 1'b1;
    tick();
    chk("obs_fault", 32'(bus.fault),    32'd1);
    chk("obs_pos",   32'(bus.position), 32'd6);
    bus.fault_clr = 1'b1;
    tick();
    chk("obs_clr_blocked", 32'(bus.fault), 32'd1);
    bus.fault_clr = 1'b0; bus.obstruction = 1'b0; bus.control = 2'b00;
    ticks(2);
    bus.fault_clr = 1'b1;
    tick();
    chk("obs_cleared", 32'(bus.fault), 32'd0);
    bus.fault_clr = 1'b0;
    ticks(3);

    // Requests at the limits
    bus.control = 2'b11;
    ticks(13);
    chk("lim_pos0", 32'(bus.position), 32'd0);
    ticks(3);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("lim_dn_moving", 32'(bus.moving), 32'd0);
    end
    bus.control = 2'b10;
    ticks(21);
    chk("lim_pos10", 32'(bus.position), 32'd10);
    ticks(3);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("lim_up_moving", 32'(bus.moving), 32'd0);
    end

    // Stop codes
    bus.control = 2'b11;
    ticks(24);
    bus.control = 2'b10;
    ticks(7);
    chk("stop_pos3", 32'(bus.position), 32'd3);
    bus.control = 2'b01;
    tick();
    chk("stop01_moving", 32'(bus.moving), 32'd0);
    ticks(3);
    bus.control = 2'b00;
    ticks(5);
    chk("stop00_pos", 32'(bus.position), 32'd3);

    // Async reset mid-move
    bus.control = 2'b10;
    ticks(18);
    bus.control = 2'b11;
    ticks(7);
    chk("ar_pos7",   32'(bus.position), 32'd7);
    chk("ar_moving", 32'(bus.moving),   32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model();
    chk("ar_s2", 32'(bus.sensor2), 32'd1);
    #2 rst = 1'b0;
    bus.control = 2'b10;
    tick();
    chk("ar_restart", 32'(bus.moving), 32'd1);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 2) bus.control = 2'($urandom_range(0, 3));
      bus.obstruction = ($urandom_range(0, 15) == 0);
      bus.fault_clr   = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
